adjust_ctrl: RTL

- Initiator side of the up/down counter control interface. Converts debounced up/down button levels into single-cycle inc/dec/en pulses for a time-field counter.
- Issues one pulse per press. If the button stays held, it auto-repeats after a hold delay.
- Sits between the button debouncers and the hours/minutes/seconds counters in the clock datapath. Timing is paced by a prescaled tick strobe.

---
 rtl/adjust_ctrl_if.sv | 34 +++
 rtl/adjust_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/adjust_ctrl_if.sv
// Control bus between the adjust controller and a time-field counter.
// The controller owns the master side and drives the inc/dec/en pulses.
interface adjust_ctrl_if;
  logic tick;
  logic arm;
  logic btn_up;
  logic btn_dn;
  logic inc;
  logic dec;
  logic en;
  logic repeating;

  modport master (
    input  tick,
    input  arm,
    input  btn_up,
    input  btn_dn,
    output inc,
    output dec,
    output en,
    output repeating
  );

  modport slave (
    output tick,
    output arm,
    output btn_up,
    output btn_dn,
    input  inc,
    input  dec,
    input  en,
    input  repeating
  );
endinterface

// File: rtl/adjust_ctrl.sv
// Turns debounced up/down button levels into single-cycle inc/dec/en pulses,
// with auto-repeat after a hold delay, paced by a prescaled tick strobe.
module adjust_ctrl #(
  parameter int CNT_BIT      = 16,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic          clk,
  input  logic          reset_n,
  adjust_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  localparam logic [CNT_BIT-1:0] HOLD_LAST   = CNT_BIT'(HOLD_TICKS - 1);
  localparam logic [CNT_BIT-1:0] REPEAT_LAST = CNT_BIT'(REPEAT_TICKS - 1);

  logic [1:0]         up_sync;
  logic [1:0]         dn_sync;
  logic               up_s;
  logic               dn_s;
  state_t             state;
  logic [CNT_BIT-1:0] cnt;
  logic               dir;
  logic               held;
  logic               inc_q;
  logic               dec_q;
  logic               en_q;
  logic               rep_q;

  assign up_s = up_sync[1];
  assign dn_s = dn_sync[1];

  // Level of whichever button started the current press.
  assign held = dir ? up_s : dn_s;

  assign bus.inc       = inc_q;
  assign bus.dec       = dec_q;
  assign bus.en        = en_q;
  assign bus.repeating = rep_q;

  // Two-flop synchronizers for the asynchronous button levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], bus.btn_up};
      dn_sync <= {dn_sync[0], bus.btn_dn};
    end
  end

  // Press / hold / repeat state machine with registered pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      en_q  <= 1'b0;
      rep_q <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      en_q  <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          rep_q <= 1'b0;
          if (bus.arm && up_s && !dn_s) begin
            inc_q <= 1'b1;
            en_q  <= 1'b1;
            dir   <= 1'b1;
            state <= HOLD;
          end else if (bus.arm && dn_s && !up_s) begin
            dec_q <= 1'b1;
            en_q  <= 1'b1;
            dir   <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!bus.arm || !held) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (bus.tick) begin
            if (cnt == HOLD_LAST) begin
              inc_q <= dir;
              dec_q <= ~dir;
              en_q  <= 1'b1;
              cnt   <= '0;
              rep_q <= 1'b1;
              state <= REPEAT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!bus.arm || !held) begin
            state <= IDLE;
            cnt   <= '0;
            rep_q <= 1'b0;
          end else if (bus.tick) begin
            if (cnt == REPEAT_LAST) begin
              inc_q <= dir;
              dec_q <= ~dir;
              en_q  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          rep_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
